// File: rtl/ts_bus_driver_monitor.sv
// ---------------------------------------------------------------------------
// ts_bus_driver_monitor
//
// Per-bus driver monitor for a shared tri-state pad bus with N_DRV drivers.
// Every cycle it registers how many drivers are enabled and what they drive
// (0, 1 or unknown), raises a multi-driver flag and reports the resolved bus
// value. Beyond plain driver counting it models a force override, filters
// contention through a persistence FSM, keeps a sticky fault and counts
// contention episodes in a saturating counter.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset      : synchronous, active-high reset
//   oe         : per-driver output enable              [N_DRV]
//   op         : per-driver data value                 [N_DRV]
//   opx        : per-driver value-unknown flag         [N_DRV]
//   force_en   : bus is forced, contention is masked
//   force_val  : forced bus value (bus encoding)       [2]
//   clr_fault  : clear the sticky fault
//   count_d    : enabled drivers                       [CW]
//   count_0    : enabled drivers driving 0             [CW]
//   count_1    : enabled drivers driving 1             [CW]
//   count_x    : enabled drivers driving X             [CW]
//   multi      : more than one enabled driver
//   forced     : registered force_en
//   bus_val    : resolved value 00=0 01=1 10=X 11=Z
//   fault      : sticky contention fault
//   cont_evts  : saturating contention event count     [EVW]
// ---------------------------------------------------------------------------
module ts_bus_driver_monitor #(
    parameter int N_DRV       = 6,
    parameter int HOLD_CYCLES = 3,
    parameter int EVW         = 8,
    localparam int CW         = $clog2(N_DRV + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DRV-1:0] oe,
    input  logic [N_DRV-1:0] op,
    input  logic [N_DRV-1:0] opx,
    input  logic             force_en,
    input  logic [1:0]       force_val,
    input  logic             clr_fault,
    output logic [CW-1:0]    count_d,
    output logic [CW-1:0]    count_0,
    output logic [CW-1:0]    count_1,
    output logic [CW-1:0]    count_x,
    output logic             multi,
    output logic             forced,
    output logic [1:0]       bus_val,
    output logic             fault,
    output logic [EVW-1:0]   cont_evts
);

    // Hold counter carries one bit of headroom so an increment past
    // HOLD_CYCLES (possible after a fault clear with HOLD_CYCLES==1)
    // cannot wrap back below the threshold.
    localparam int HW = $clog2(HOLD_CYCLES + 2);

    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0]  HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0]  HOLD_ONE  = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [EVW-1:0] EVT_SAT   = {EVW{1'b1}};

    localparam logic [1:0] BUS_0 = 2'b00;
    localparam logic [1:0] BUS_1 = 2'b01;
    localparam logic [1:0] BUS_X = 2'b10;
    localparam logic [1:0] BUS_Z = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_MULTI  = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    state_t          state_r;
    state_t          state_raw_s;
    state_t          state_nx_s;
    state_t          fall_s;
    logic [HW-1:0]   hold_r;
    logic [HW-1:0]   hold_raw_s;
    logic [HW-1:0]   hold_nx_s;
    logic [CW-1:0]   cnt_d_s;
    logic [CW-1:0]   cnt_0_s;
    logic [CW-1:0]   cnt_1_s;
    logic [CW-1:0]   cnt_x_s;
    logic [1:0]      bus_s;
    logic            m_s;
    logic            evt_s;
    logic            fault_nx_s;

    // Driver counts over all pads for the current input sample
    always_comb begin
        cnt_d_s = CNT_ZERO;
        cnt_0_s = CNT_ZERO;
        cnt_1_s = CNT_ZERO;
        cnt_x_s = CNT_ZERO;
        for (int i = 0; i < N_DRV; i++) begin
            if (oe[i]) begin
                cnt_d_s = cnt_d_s + CNT_ONE;
                if (opx[i]) begin
                    cnt_x_s = cnt_x_s + CNT_ONE;
                end else if (op[i]) begin
                    cnt_1_s = cnt_1_s + CNT_ONE;
                end else begin
                    cnt_0_s = cnt_0_s + CNT_ONE;
                end
            end else begin
                cnt_d_s = cnt_d_s;
            end
        end
    end

    // Bus resolution: force wins, then Z / clean 0 / clean 1 / conflict X
    always_comb begin
        bus_s = BUS_Z;
        if (force_en) begin
            bus_s = force_val;
        end else if (cnt_d_s == CNT_ZERO) begin
            bus_s = BUS_Z;
        end else if ((cnt_x_s != CNT_ZERO) ||
                     ((cnt_0_s != CNT_ZERO) && (cnt_1_s != CNT_ZERO))) begin
            bus_s = BUS_X;
        end else if (cnt_0_s != CNT_ZERO) begin
            bus_s = BUS_0;
        end else begin
            bus_s = BUS_1;
        end
    end

    // Contention FSM next state; a forced bus never counts as contention
    always_comb begin
        m_s         = (cnt_d_s > CNT_ONE) && !force_en;
        fall_s      = (cnt_d_s == CNT_ZERO) ? ST_IDLE : ST_SINGLE;
        state_raw_s = state_r;
        hold_raw_s  = hold_r;
        evt_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_SINGLE: begin
                if (m_s) begin
                    evt_s = 1'b1;
                    if (HOLD_CYCLES == 1) begin
                        state_raw_s = ST_FAULT;
                        hold_raw_s  = HOLD_ONE;
                    end else begin
                        state_raw_s = ST_MULTI;
                        hold_raw_s  = HOLD_ONE;
                    end
                end else begin
                    state_raw_s = fall_s;
                    hold_raw_s  = HOLD_ZERO;
                end
            end
            ST_MULTI: begin
                if (m_s) begin
                    hold_raw_s  = hold_r + HOLD_ONE;
                    state_raw_s = (hold_raw_s >= HOLD_MAX) ? ST_FAULT : ST_MULTI;
                end else begin
                    state_raw_s = fall_s;
                    hold_raw_s  = HOLD_ZERO;
                end
            end
            ST_FAULT: begin
                if (m_s) begin
                    state_raw_s = ST_FAULT;
                end else begin
                    state_raw_s = fall_s;
                    hold_raw_s  = HOLD_ZERO;
                end
            end
            default: begin
                state_raw_s = ST_IDLE;
                hold_raw_s  = HOLD_ZERO;
            end
        endcase

        // A clear beats a simultaneous fault entry: persistence restarts
        // from one sample so the fault re-arms after HOLD_CYCLES-1 more.
        if (clr_fault && (state_raw_s == ST_FAULT)) begin
            state_nx_s = ST_MULTI;
            hold_nx_s  = HOLD_ONE;
        end else begin
            state_nx_s = state_raw_s;
            hold_nx_s  = hold_raw_s;
        end

        fault_nx_s = clr_fault ? 1'b0 : (fault | (state_nx_s == ST_FAULT));
    end

    // State, hold counter and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            hold_r    <= HOLD_ZERO;
            count_d   <= CNT_ZERO;
            count_0   <= CNT_ZERO;
            count_1   <= CNT_ZERO;
            count_x   <= CNT_ZERO;
            multi     <= 1'b0;
            forced    <= 1'b0;
            bus_val   <= BUS_Z;
            fault     <= 1'b0;
            cont_evts <= {EVW{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            hold_r    <= hold_nx_s;
            count_d   <= cnt_d_s;
            count_0   <= cnt_0_s;
            count_1   <= cnt_1_s;
            count_x   <= cnt_x_s;
            multi     <= (cnt_d_s > CNT_ONE);
            forced    <= force_en;
            bus_val   <= bus_s;
            fault     <= fault_nx_s;
            if (evt_s && (cont_evts != EVT_SAT)) begin
                cont_evts <= cont_evts + {{(EVW-1){1'b0}}, 1'b1};
            end else begin
                cont_evts <= cont_evts;
            end
        end
    end

endmodule

// File: tb/tb_ts_bus_driver_monitor.sv
// ---------------------------------------------------------------------------
// tb_ts_bus_driver_monitor
//
// Directed scoreboard bench: each stimulus cycle pushes its hand-computed
// expected output record into a queue; an independent monitor pops one
// record per clock, just after the edge, and compares every output.
// ---------------------------------------------------------------------------
module tb_ts_bus_driver_monitor;

    typedef struct packed {
        logic [2:0] cd;
        logic [2:0] c0;
        logic [2:0] c1;
        logic [2:0] cx;
        logic       multi;
        logic       forced;
        logic [1:0] bus;
        logic       fault;
        logic [7:0] evts;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [5:0] oe;
    logic [5:0] op;
    logic [5:0] opx;
    logic       force_en;
    logic [1:0] force_val;
    logic       clr_fault;
    logic [2:0] count_d;
    logic [2:0] count_0;
    logic [2:0] count_1;
    logic [2:0] count_x;
    logic       multi;
    logic       forced;
    logic [1:0] bus_val;
    logic       fault;
    logic [7:0] cont_evts;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    ts_bus_driver_monitor #(.N_DRV(6), .HOLD_CYCLES(3), .EVW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .oe        (oe),
        .op        (op),
        .opx       (opx),
        .force_en  (force_en),
        .force_val (force_val),
        .clr_fault (clr_fault),
        .count_d   (count_d),
        .count_0   (count_0),
        .count_1   (count_1),
        .count_x   (count_x),
        .multi     (multi),
        .forced    (forced),
        .bus_val   (bus_val),
        .fault     (fault),
        .cont_evts (cont_evts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input int cd, input int c0, input int c1, input int cx,
                                input int mu, input int fo, input logic [1:0] bus,
                                input int fa, input int ev);
        exp_t e;
        e.cd     = 3'(cd);
        e.c0     = 3'(c0);
        e.c1     = 3'(c1);
        e.cx     = 3'(cx);
        e.multi  = 1'(mu);
        e.forced = 1'(fo);
        e.bus    = bus;
        e.fault  = 1'(fa);
        e.evts   = 8'(ev);
        return e;
    endfunction

    // Queue the expectation for the inputs currently applied, then clock once
    task automatic step(input string tag, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one record per clock, sampled 1 time unit after the edge
    initial begin
        exp_t  e;
        exp_t  a;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {count_d, count_0, count_1, count_x, multi, forced,
                     bus_val, fault, cont_evts};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got d=%0d 0=%0d 1=%0d x=%0d multi=%b forced=%b bus=%b fault=%b evts=%0d want d=%0d 0=%0d 1=%0d x=%0d multi=%b forced=%b bus=%b fault=%b evts=%0d",
                             t, a.cd, a.c0, a.c1, a.cx, a.multi, a.forced, a.bus, a.fault, a.evts,
                             e.cd, e.c0, e.c1, e.cx, e.multi, e.forced, e.bus, e.fault, e.evts);
                end
            end
        end
    end

    initial begin
        int ev;
        reset     = 1'b1;
        oe        = 6'b000000;
        op        = 6'b000000;
        opx       = 6'b000000;
        force_en  = 1'b0;
        force_val = 2'b00;
        clr_fault = 1'b0;

        // 1: reset, no drivers
        step("reset_a", mk(0, 0, 0, 0, 0, 0, 2'b11, 0, 0));
        step("reset_b", mk(0, 0, 0, 0, 0, 0, 2'b11, 0, 0));
        reset = 1'b0;
        step("idle", mk(0, 0, 0, 0, 0, 0, 2'b11, 0, 0));

        // 2: single driver 0, then add driver 1 at 1
        oe = 6'b000001; op = 6'b000000;
        step("single0", mk(1, 1, 0, 0, 0, 0, 2'b00, 0, 0));
        oe = 6'b000011; op = 6'b000010;
        step("multi_h1", mk(2, 1, 1, 0, 1, 0, 2'b10, 0, 1));

        // 3: persistence: fault only on the third contended sample
        step("multi_h2", mk(2, 1, 1, 0, 1, 0, 2'b10, 0, 1));
        step("fault_h3", mk(2, 1, 1, 0, 1, 0, 2'b10, 1, 1));
        oe = 6'b000001;
        step("drop1_sticky", mk(1, 1, 0, 0, 0, 0, 2'b00, 1, 1));

        // 4: drivers 0 (0), 2 (1), 4 (X, op ignored); op[5] on a disabled pad
        oe = 6'b010101; op = 6'b110100; opx = 6'b010000;
        step("x_h1", mk(3, 1, 1, 1, 1, 0, 2'b10, 1, 2));
        step("x_h2", mk(3, 1, 1, 1, 1, 0, 2'b10, 1, 2));
        step("x_h3", mk(3, 1, 1, 1, 1, 0, 2'b10, 1, 2));
        clr_fault = 1'b1;
        step("clr_a", mk(3, 1, 1, 1, 1, 0, 2'b10, 0, 2));
        clr_fault = 1'b0;
        step("clr_b", mk(3, 1, 1, 1, 1, 0, 2'b10, 0, 2));
        step("refault", mk(3, 1, 1, 1, 1, 0, 2'b10, 1, 2));

        // 5: forced bus with two drivers: no contention, clear fault first
        oe = 6'b000011; op = 6'b000010; opx = 6'b000000;
        force_en = 1'b1; force_val = 2'b01; clr_fault = 1'b1;
        step("force_clr", mk(2, 1, 1, 0, 1, 1, 2'b01, 0, 2));
        clr_fault = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step("force_hold", mk(2, 1, 1, 0, 1, 1, 2'b01, 0, 2));
        end
        force_en = 1'b0;
        step("unforce", mk(2, 1, 1, 0, 1, 0, 2'b10, 0, 3));

        // 6: toggle contention 300 times, counter saturates at 255
        oe = 6'b000000;
        step("tog_off0", mk(0, 0, 0, 0, 0, 0, 2'b11, 0, 3));
        ev = 3;
        for (int k = 0; k < 300; k++) begin
            ev = (ev == 255) ? 255 : ev + 1;
            oe = 6'b000011;
            step("tog_on", mk(2, 1, 1, 0, 1, 0, 2'b10, 0, ev));
            oe = 6'b000000;
            step("tog_off", mk(0, 0, 0, 0, 0, 0, 2'b11, 0, ev));
        end
        oe = 6'b000011;
        step("sat_255", mk(2, 1, 1, 0, 1, 0, 2'b10, 0, 255));
        reset = 1'b1;
        step("reset_mid", mk(0, 0, 0, 0, 0, 0, 2'b11, 0, 0));
        reset = 1'b0;
        step("after_reset", mk(2, 1, 1, 0, 1, 0, 2'b10, 0, 1));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
